// File: rtl/spi_byte_tx_if.sv
// Producer handshake plus SPI pins for spi_byte_tx.
// The transmitter uses the slave view; the byte producer uses the master view.
interface spi_byte_tx_if;
    logic [7:0] data;
    logic       sendEnable;
    logic       sendBusy;
    logic       tx_done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;

    modport slave (
        input  data, sendEnable,
        output sendBusy, tx_done, spi_sclk, spi_mosi, spi_cs_n
    );

    modport master (
        output data, sendEnable,
        input  sendBusy, tx_done, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode-0 master that sends one byte per sendEnable handshake.
// Each byte gets its own chip-select window, followed by a chip-select-high gap.
module spi_byte_tx #(
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic          baseClk,
    input logic          hard_Clr_n,
    spi_byte_tx_if.slave tx
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       armed_q, armed_d;
    logic       busy_q, busy_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       csn_q, csn_d;
    logic       done_q, done_d;

    function automatic logic leadBit(input logic [7:0] v);
        return LSB_FIRST ? v[0] : v[7];
    endfunction

    function automatic logic [7:0] shiftOn(input logic [7:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    always_ff @(posedge baseClk or negedge hard_Clr_n) begin
        if (!hard_Clr_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b1;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            done_q  <= done_d;
        end
    end

    // armed re-arms on any low sendEnable cycle so one held level yields one byte
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = tx.sendEnable ? armed_q : 1'b1;
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx.sendEnable && armed_q) begin
                    shift_d = tx.data;
                    mosi_d  = leadBit(tx.data);
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    armed_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        sclk_d = ~sclk_q;
                        // falling edge: present the next bit while sclk is low
                        if (sclk_q) begin
                            shift_d = shiftOn(shift_q);
                            mosi_d  = leadBit(shiftOn(shift_q));
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    csn_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
                shift_d = '0;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                csn_d   = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    assign tx.sendBusy = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.spi_sclk = sclk_q;
    assign tx.spi_mosi = mosi_q;
    assign tx.spi_cs_n = csn_q;
endmodule

// File: tb/tb_spi_byte_tx.sv
// Bench for spi_byte_tx: instance 0 uses defaults, instance 1 is LSB-first with CLK_DIV=2, CS_GAP=1.
// A wire-level monitor rebuilds each byte from SCLK rising edges and times busy/cs windows.
module tb_spi_byte_tx;
    localparam int DIV_A = 4, GAP_A = 4, DIV_B = 2, GAP_B = 1;

    logic baseClk = 1'b0;
    logic resetN  = 1'b0;
    always #5 baseClk = ~baseClk;

    spi_byte_tx_if ifA ();
    spi_byte_tx_if ifB ();

    spi_byte_tx #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A), .LSB_FIRST(1'b0)) dutA (
        .baseClk(baseClk), .hard_Clr_n(resetN), .tx(ifA)
    );
    spi_byte_tx #(.CLK_DIV(DIV_B), .CS_GAP(GAP_B), .LSB_FIRST(1'b1)) dutB (
        .baseClk(baseClk), .hard_Clr_n(resetN), .tx(ifB)
    );

    logic       enS[2];
    logic [7:0] dataS[2];
    logic       sclkS[2], mosiS[2], csS[2], busyS[2], doneS[2];

    assign ifA.sendEnable = enS[0];
    assign ifA.data       = dataS[0];
    assign ifB.sendEnable = enS[1];
    assign ifB.data       = dataS[1];
    assign sclkS[0] = ifA.spi_sclk;
    assign mosiS[0] = ifA.spi_mosi;
    assign csS[0]   = ifA.spi_cs_n;
    assign busyS[0] = ifA.sendBusy;
    assign doneS[0] = ifA.tx_done;
    assign sclkS[1] = ifB.spi_sclk;
    assign mosiS[1] = ifB.spi_mosi;
    assign csS[1]   = ifB.spi_cs_n;
    assign busyS[1] = ifB.sendBusy;
    assign doneS[1] = ifB.tx_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int byteCount[2] = '{0, 0};
    int doneCount[2] = '{0, 0};
    int protoErr[2]  = '{0, 0};
    int curRises[2]  = '{0, 0};
    int lastRises[2] = '{0, 0};
    int lastCsLow[2] = '{0, 0};
    int lastBusy[2]  = '{0, 0};
    int period[2]    = '{0, 0};
    int riseT[2]     = '{0, 0};
    int csRun[2]     = '{0, 0};
    int busyRun[2]   = '{0, 0};
    logic [7:0] cur[2]      = '{8'h00, 8'h00};
    logic [7:0] lastByte[2] = '{8'h00, 8'h00};
    logic firstBit[2] = '{1'b0, 1'b0};
    logic inByte[2]   = '{1'b0, 1'b0};
    logic csP[2]      = '{1'b1, 1'b1};
    logic sclkP[2]    = '{1'b0, 1'b0};
    logic mosiP[2]    = '{1'b0, 1'b0};
    logic busyP[2]    = '{1'b0, 1'b0};

    function automatic int divOf(input int k);
        return (k == 1) ? DIV_B : DIV_A;
    endfunction

    function automatic int gapOf(input int k);
        return (k == 1) ? GAP_B : GAP_A;
    endfunction

    // Reconstruct what a mode-0 slave would see, sampling away from the active edge
    always @(negedge baseClk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!resetN) begin
                inByte[k]   = 1'b0;
                curRises[k] = 0;
                busyRun[k]  = 0;
                csP[k]      = 1'b1;
                sclkP[k]    = 1'b0;
                mosiP[k]    = 1'b0;
                busyP[k]    = 1'b0;
            end else begin
                if (csP[k] && !csS[k]) begin
                    inByte[k]   = 1'b1;
                    curRises[k] = 0;
                    cur[k]      = 8'h00;
                    csRun[k]    = 0;
                end
                if (!csS[k]) csRun[k]++;
                if (!sclkP[k] && sclkS[k]) begin
                    if (csS[k]) protoErr[k]++;
                    cur[k] = (k == 1) ? {mosiS[k], cur[k][7:1]} : {cur[k][6:0], mosiS[k]};
                    curRises[k]++;
                    if (curRises[k] == 1) firstBit[k] = mosiS[k];
                    if (curRises[k] == 2) period[k] = cyc - riseT[k];
                    riseT[k] = cyc;
                end
                if (sclkP[k] && sclkS[k] && (mosiS[k] != mosiP[k])) protoErr[k]++;
                if (!csP[k] && csS[k] && inByte[k]) begin
                    lastByte[k]  = cur[k];
                    lastRises[k] = curRises[k];
                    lastCsLow[k] = csRun[k];
                    byteCount[k]++;
                    inByte[k] = 1'b0;
                end
                if (busyS[k]) busyRun[k]++;
                if (doneS[k]) begin
                    doneCount[k]++;
                    if (!(busyP[k] && !busyS[k])) protoErr[k]++;
                end
                if (busyP[k] && !busyS[k]) begin
                    lastBusy[k] = busyRun[k];
                    busyRun[k]  = 0;
                end
                csP[k]   = csS[k];
                sclkP[k] = sclkS[k];
                mosiP[k] = mosiS[k];
                busyP[k] = busyS[k];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One handshake; the reference expects the byte unchanged on the wire and spec-derived timing
    task automatic applyStimulus(input int k, input logic [7:0] b, input int changeEdge, input logic [7:0] newData);
        int bc0;
        int dc0;
        bit seen;
        bc0 = byteCount[k];
        dc0 = doneCount[k];
        @(negedge baseClk);
        dataS[k] = b;
        enS[k]   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge baseClk);
            seen = busyS[k];
        end
        checkOutput("accept", 32'(seen), 32'd1);
        enS[k] = 1'b0;
        if (changeEdge > 0) begin
            for (int i = 0; i < 400 && curRises[k] < changeEdge; i++) @(negedge baseClk);
        end
        dataS[k] = newData;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge baseClk);
            seen = !busyS[k];
        end
        checkOutput("busyEnd", 32'(seen), 32'd1);
        repeat (2) @(negedge baseClk);
        checkOutput("byte", 32'(lastByte[k]), 32'(b));
        checkOutput("firstBit", 32'(firstBit[k]), (k == 1) ? 32'(b[0]) : 32'(b[7]));
        checkOutput("rises", 32'(lastRises[k]), 32'd8);
        checkOutput("csLow", 32'(lastCsLow[k]), 32'(18 * divOf(k)));
        checkOutput("busyLen", 32'(lastBusy[k]), 32'(18 * divOf(k) + gapOf(k)));
        checkOutput("sclkPeriod", 32'(period[k]), 32'(2 * divOf(k)));
        checkOutput("byteCount", 32'(byteCount[k] - bc0), 32'd1);
        checkOutput("doneCount", 32'(doneCount[k] - dc0), 32'd1);
        repeat ($urandom_range(0, 5)) @(negedge baseClk);
    endtask

    initial begin
        int bc0;
        int busySeen;
        bit seen;
        logic [7:0] r;
        logic [7:0] frame [5];
        frame = '{8'hFF, 8'h78, 8'h56, 8'h34, 8'h12};

        enS[0] = 1'b0;
        enS[1] = 1'b0;
        dataS[0] = 8'h00;
        dataS[1] = 8'h00;
        repeat (3) @(negedge baseClk);
        checkOutput("rstBusyA", 32'(ifA.sendBusy), 32'd0);
        checkOutput("rstSclkA", 32'(ifA.spi_sclk), 32'd0);
        checkOutput("rstMosiA", 32'(ifA.spi_mosi), 32'd0);
        checkOutput("rstCsA",   32'(ifA.spi_cs_n), 32'd1);
        checkOutput("rstDoneA", 32'(ifA.tx_done),  32'd0);
        checkOutput("rstCsB",   32'(ifB.spi_cs_n), 32'd1);
        checkOutput("rstBusyB", 32'(ifB.sendBusy), 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge baseClk);

        $display("[TB] single byte 0xA5");
        applyStimulus(0, 8'hA5, 0, 8'h00);

        $display("[TB] five-byte frame");
        foreach (frame[i]) applyStimulus(0, frame[i], 0, 8'(~frame[i]));

        $display("[TB] stuck-high sendEnable");
        bc0 = byteCount[0];
        @(negedge baseClk);
        dataS[0] = 8'h3C;
        enS[0]   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge baseClk);
            seen = busyS[0];
        end
        checkOutput("stuckAccept", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge baseClk);
            seen = !busyS[0];
        end
        checkOutput("stuckBusyEnd", 32'(seen), 32'd1);
        busySeen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge baseClk);
            if (busyS[0]) busySeen++;
        end
        checkOutput("stuckNoRepeat", 32'(busySeen), 32'd0);
        checkOutput("stuckByteCount", 32'(byteCount[0] - bc0), 32'd1);
        checkOutput("stuckByte", 32'(lastByte[0]), 32'h3C);
        enS[0] = 1'b0;
        applyStimulus(0, 8'h3C, 0, 8'h00);

        $display("[TB] LSB-first fast instance, 0x01");
        applyStimulus(1, 8'h01, 0, 8'hFF);

        $display("[TB] mid-byte reset");
        bc0 = byteCount[0];
        @(negedge baseClk);
        dataS[0] = 8'hC3;
        enS[0]   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge baseClk);
            seen = busyS[0];
        end
        checkOutput("midAccept", 32'(seen), 32'd1);
        enS[0] = 1'b0;
        for (int i = 0; i < 400 && curRises[0] < 3; i++) @(negedge baseClk);
        checkOutput("midReachedEdge3", 32'(curRises[0] >= 3), 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("midCs",   32'(ifA.spi_cs_n), 32'd1);
        checkOutput("midSclk", 32'(ifA.spi_sclk), 32'd0);
        checkOutput("midBusy", 32'(ifA.sendBusy), 32'd0);
        repeat (3) @(negedge baseClk);
        resetN = 1'b1;
        busySeen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge baseClk);
            if (busyS[0] || !csS[0]) busySeen++;
        end
        checkOutput("midNoResume", 32'(busySeen), 32'd0);
        checkOutput("midNoPartial", 32'(byteCount[0] - bc0), 32'd0);
        applyStimulus(0, 8'h5A, 0, 8'h00);

        $display("[TB] data change during shift");
        applyStimulus(0, 8'hF0, 2, 8'h0F);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 10; n++) begin
            r = 8'($urandom);
            applyStimulus(0, r, int'($urandom_range(0, 7)), 8'($urandom));
        end
        for (int n = 0; n < 6; n++) begin
            r = 8'($urandom);
            applyStimulus(1, r, int'($urandom_range(0, 7)), 8'($urandom));
        end

        checkOutput("protocolA", 32'(protoErr[0]), 32'd0);
        checkOutput("protocolB", 32'(protoErr[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- SPI-master byte transmitter. It sits downstream of freqMeasure_Mod, on the other end of its sendEnable/sendBusy/data byte handshake.
- It accepts one byte per handshake, shifts it out in SPI mode 0 with a per-byte chip select, and holds sendBusy high until the byte and the inter-byte gap are complete.
- It runs entirely on baseClk, so there is no clock-domain crossing.

Parameters:
- CLK_DIV, 4: baseClk cycles per SCLK half-period. Legal range 2..255.
- CS_GAP, 4: baseClk cycles spi_cs_n stays high after each byte before sendBusy drops. Legal range 1..255.
- LSB_FIRST, 0: 0 shifts bit7 first; 1 shifts bit0 first.

Ports:
- baseClk, input, 1: system clock.
- hard_Clr_n, input, 1: asynchronous active-low reset.
- data, input, 8: byte to send. Sampled only in the accept cycle.
- sendEnable, input, 1: producer request, level. The producer holds it until it sees sendBusy, then drops it.
- sendBusy, output, 1: high from the cycle after accept until the byte, hold and gap are all done.
- spi_sclk, output, 1: SPI clock. Idles low (CPOL=0).
- spi_mosi, output, 1: serial data. Changes only while spi_sclk is low.
- spi_cs_n, output, 1: active-low chip select, asserted once per byte.
- tx_done, output, 1: one-cycle pulse in the cycle sendBusy falls.

Behaviour:
- Reset (hard_Clr_n=0, asynchronous):
  - state=IDLE, sendBusy=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, tx_done=0.
  - Shift register=0, divider=0, bit counter=0, armed=1.
- Reset asserted mid-byte aborts immediately:
  - spi_cs_n goes high asynchronously.
  - No partial byte is resumed after release.
- armed flag:
  - Cleared on accept.
  - Set on any cycle with sendEnable=0.
  - Guarantees that a single sendEnable level is never accepted twice.
- Accept condition: state=IDLE, sendEnable=1 and armed=1, in cycle T.
  - data is latched into the shift register at T.
  - At T+1: sendBusy=1, spi_cs_n=0, spi_mosi=first bit, state=SETUP.
- States:
  - IDLE: waits for the accept condition.
  - SETUP: spi_cs_n low, spi_sclk low, for CLK_DIV cycles. Then goes to SHIFT.
  - SHIFT: 16 half-periods of CLK_DIV cycles each.
    - Odd half-periods start with a rising edge; the slave samples on the rising edge.
    - Even half-periods start with a falling edge; spi_mosi advances to the next bit in that same cycle.
    - After the 16th half-period (8th falling edge, spi_sclk low), goes to HOLD.
  - HOLD: spi_cs_n low, spi_sclk low, for CLK_DIV cycles. Then spi_cs_n=1 and goes to GAP.
  - GAP: spi_cs_n high for CS_GAP cycles.
    - On exit: sendBusy=0, tx_done=1 for one cycle, state=IDLE, spi_mosi=0.
- Latency: sendBusy is high for exactly 18*CLK_DIV + CS_GAP cycles. With defaults this is 76 cycles.
- Back-to-back bytes:
  - The earliest next accept is the cycle after sendBusy falls, provided armed was restored during busy.
  - The producer's drop-enable-then-reassert pattern therefore yields one byte per handshake.
- sendEnable rising while busy: ignored. The byte is accepted only after busy ends, and only if armed has been restored by a cycle with sendEnable=0.
- data changing after accept: has no effect on the byte in flight.
- Counters:
  - The divider counts 0..CLK_DIV-1 and wraps.
  - The bit counter is 4 bits, counts half-periods 0..15, and never overflows past 15.
- No error state: illegal state encodings recover to IDLE with outputs at their reset values.

Test Plan:
- Reset then single byte: data=0xA5, pulse sendEnable, defaults.
  - Expect sendBusy high for 76 cycles and 8 rising SCLK edges.
  - Sampled MOSI = 1,0,1,0,0,1,0,1.
  - cs_n low for 72 cycles; one tx_done pulse.
- Full frame: the producer sends 0xFF,0x78,0x56,0x34,0x12 via handshake.
  - Expect 5 cs_n windows with bytes exactly in that order.
  - Expect 5 tx_done pulses and no duplicate bytes.
- Stuck-high sendEnable: hold sendEnable=1 continuously with data=0x3C.
  - Expect exactly one byte sent; sendBusy stays 0 afterwards until sendEnable drops and rises again.
- LSB_FIRST=1, CLK_DIV=2, CS_GAP=1, data=0x01.
  - Expect the first sampled bit = 1 and the rest = 0.
  - Expect busy = 37 cycles and an SCLK period of 4 cycles.
- Mid-byte reset: assert hard_Clr_n low after the 3rd rising edge.
  - Expect cs_n=1, sclk=0 and sendBusy=0 immediately.
  - After release, a new byte 0x5A transmits cleanly.
- data change during SHIFT: change data from 0xF0 to 0x0F at the 2nd edge.
  - Expect 0xF0 on the wire.
